background_model_stream: RTL
============================

Name: background_model_stream

Overview:
- Parametrised successor of the per-pixel running-average background model in the frame_difference IP.
- Accepts streamed pixel triples (current, previous, background) and emits per pixel:
  - the updated background;
  - a foreground mask (current vs background);
  - a movement mask (current vs previous).
- Adds valid/ready flow control, a generic channel count and width, and selectable update modes.
- Adds a per-frame foreground pixel counter.
- Sits between the VDMA frame readers and the mask/background writers.

Parameters:
- CHANNELS, 3, number of colour channels per pixel; channel 0 is luma (MSB-most slice).
- CH_WIDTH, 8, bits per channel.
- ALPHA_FRAC, 7, fractional bits of alpha; 1.0 = 2^ALPHA_FRAC.
- LUMA_SHIFT, 0, left shift applied to the luma difference in the weighted sum.
- CHROMA_SHIFT, 1, left shift applied to the summed chroma differences.
- CNT_WIDTH, 24, width of the foreground counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept a pixel.
- s_last  in  1  last pixel of frame.
- s_current  in  CHANNELS*CH_WIDTH  current frame pixel; channel k at bits [(CHANNELS-k)*CH_WIDTH-1 -: CH_WIDTH].
- s_previous  in  CHANNELS*CH_WIDTH  previous frame pixel.
- s_background  in  CHANNELS*CH_WIDTH  stored background pixel.
- alpha  in  ALPHA_FRAC+1  learning rate; values above 2^ALPHA_FRAC are clamped to 2^ALPHA_FRAC.
- bg_th  in  CH_WIDTH+4  foreground threshold.
- fd_th  in  CH_WIDTH  movement threshold.
- mode  in  2  0 = selective update, 1 = always update, 2 = freeze, 3 = reset-to-current.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  delayed s_last.
- m_background  out  CHANNELS*CH_WIDTH  updated background.
- m_foreground  out  CHANNELS*CH_WIDTH  all-ones if foreground, else 0.
- m_movement  out  CHANNELS*CH_WIDTH  all-ones if moving, else 0.
- fg_count  out  CNT_WIDTH  foreground pixel count of the last completed frame.
- fg_count_valid  out  1  one-cycle pulse when fg_count updates.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - all pipeline valids clear; m_valid=0, m_last=0;
  - all data outputs 0; fg_count=0, fg_count_valid=0; running counter 0.
  - s_ready=1 in the cycle after reset.
  - Reset mid-frame discards all in-flight pixels and the partial count.
- **Pipeline:** 4 stages, fixed latency 4 accepted-cycles from an s_valid&&s_ready handshake to m_valid for that pixel.
  - Global advance enable en = !m_valid || m_ready; s_ready = en.
  - When en=0, every stage holds data and valid.
  - Bubbles (s_valid=0) propagate as invalid stages.
- **Control sampling:** alpha, bg_th, fd_th and mode are sampled at the input handshake and travel with the pixel, so mid-frame changes affect only later pixels.
- **Stage 1:** per channel, abs diff d_k = |cur_k - bg_k|; movement diff m = |cur_0 - prev_0|.
- **Stage 2:** weighted sum W = (d_0 << LUMA_SHIFT) + ((sum over k>=1 of d_k) << CHROMA_SHIFT).
  - Computed at full width, CH_WIDTH+ceil(log2(CHANNELS))+max shift bits; no truncation or wrap.
  - fg = W > bg_th (zero-extended); mov = m > fd_th.
- **Stage 3:** per channel blend with a = clamped alpha, A1 = 2^ALPHA_FRAC - a.
  - upd_k = (a*cur_k + A1*bg_k + 2^(ALPHA_FRAC-1)) >> ALPHA_FRAC.
  - Rounded; the result never exceeds 2^CH_WIDTH-1.
- **Stage 4:** background select.
  - mode 0: upd if !fg && !mov, else bg.
  - mode 1: upd.
  - mode 2: bg.
  - mode 3: cur.
  - Masks are expanded to all channels.
- **Counter:** increments on each output handshake (m_valid&&m_ready) with fg=1.
  - On a handshake with m_last=1: fg_count takes the final count including that pixel, fg_count_valid pulses for 1 cycle, and the running counter clears to 0.
  - The counter saturates at 2^CNT_WIDTH-1.
- m_last follows its pixel exactly. A frame of a single pixel (s_last on the first pixel) is legal.

Test Plan:
- **Reset:** rst high 2 cycles mid-stream -> m_valid=0, fg_count=0, s_ready=1 the next cycle; pixels accepted before reset never appear on the output.
- **Selective update:** mode=0, alpha=32, cur=0x804020, bg=0x804020, prev=0x804020 -> 4 cycles later m_background=0x804020, masks 0.
- **Blend:** mode=1, alpha=32, cur=0xFF0000, bg=0x000000, prev=0xFF0000.
  - Luma upd=(32*255+64)>>7=64, so m_background=0x400000.
  - With bg_th=100, W=255 -> m_foreground=0xFFFFFF.
  - mov=0 -> m_movement=0.
- **No wrap:** cur=0xFF00FF, bg=0x00FF00, bg_th=1000 -> W=255+(510<<1)=1275 > 1000 -> foreground set; bg_th=1275 -> foreground clear.
- **Backpressure:** stream 8 pixels with m_ready toggled 1,0,0,1,... -> the output sequence is identical and complete; outputs stay stable while m_valid&&!m_ready; s_ready=0 exactly in those cycles.
- **Counter:** 16-pixel frame with 5 foreground pixels, s_last on pixel 16 -> fg_count=5 with a 1-cycle fg_count_valid at the last handshake; the next frame starts counting from 0. alpha=200 is clamped to 128 and upd=cur.

Source files
------------

// File: rtl/background_model_stream.sv
// Streaming per-pixel running-average background model: four-stage pipeline
// producing updated background, foreground/movement masks and a per-frame foreground count.
module background_model_stream #(
    parameter int CHANNELS     = 3,
    parameter int CH_WIDTH     = 8,
    parameter int ALPHA_FRAC   = 7,
    parameter int LUMA_SHIFT   = 0,
    parameter int CHROMA_SHIFT = 1,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_last,
    input  logic [CHANNELS*CH_WIDTH-1:0] s_current,
    input  logic [CHANNELS*CH_WIDTH-1:0] s_previous,
    input  logic [CHANNELS*CH_WIDTH-1:0] s_background,
    input  logic [ALPHA_FRAC:0]          alpha,
    input  logic [CH_WIDTH+3:0]          bg_th,
    input  logic [CH_WIDTH-1:0]          fd_th,
    input  logic [1:0]                   mode,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [CHANNELS*CH_WIDTH-1:0] m_background,
    output logic [CHANNELS*CH_WIDTH-1:0] m_foreground,
    output logic [CHANNELS*CH_WIDTH-1:0] m_movement,
    output logic [CNT_WIDTH-1:0]         fg_count,
    output logic                         fg_count_valid
);

    localparam int PW    = CHANNELS * CH_WIDTH;
    localparam int AW    = ALPHA_FRAC + 1;
    localparam int MAXSH = (LUMA_SHIFT > CHROMA_SHIFT) ? LUMA_SHIFT : CHROMA_SHIFT;
    localparam int SW    = CH_WIDTH + $clog2(CHANNELS) + MAXSH + 1;
    localparam int TW    = CH_WIDTH + 4;
    localparam int CW    = (SW > TW) ? SW : TW;
    localparam int BW    = CH_WIDTH + ALPHA_FRAC + 2;
    localparam logic [AW-1:0] A_ONE = AW'(1) << ALPHA_FRAC;
    localparam logic [BW-1:0] HALF  = BW'(1) << (ALPHA_FRAC - 1);

    typedef enum logic [1:0] {
        MODE_SELECTIVE = 2'd0,
        MODE_ALWAYS    = 2'd1,
        MODE_FREEZE    = 2'd2,
        MODE_CURRENT   = 2'd3
    } mode_t;

    logic en;
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    // ---------------- stage 1: absolute differences ----------------
    logic [PW-1:0]       diff;
    logic [CH_WIDTH-1:0] cur_luma, prev_luma, mdiff;
    logic [AW-1:0]       alpha_clamped;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_diff
        localparam int HI = (CHANNELS - gi) * CH_WIDTH - 1;
        logic [CH_WIDTH-1:0] c, b;
        assign c = s_current[HI -: CH_WIDTH];
        assign b = s_background[HI -: CH_WIDTH];
        assign diff[HI -: CH_WIDTH] = (c >= b) ? c - b : b - c;
    end

    if (CHANNELS > 1) begin : g_unused
        logic unused_prev;
        assign unused_prev = ^s_previous[PW-CH_WIDTH-1:0];
    end

    assign cur_luma      = s_current[PW-1 -: CH_WIDTH];
    assign prev_luma     = s_previous[PW-1 -: CH_WIDTH];
    assign mdiff         = (cur_luma >= prev_luma) ? cur_luma - prev_luma : prev_luma - cur_luma;
    assign alpha_clamped = (alpha > A_ONE) ? A_ONE : alpha;

    logic                s1_valid, s1_last;
    logic [PW-1:0]       s1_cur, s1_bg, s1_diff;
    logic [CH_WIDTH-1:0] s1_mdiff, s1_fd_th;
    logic [AW-1:0]       s1_alpha;
    logic [TW-1:0]       s1_bg_th;
    mode_t               s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cur   <= '0;
            s1_bg    <= '0;
            s1_diff  <= '0;
            s1_mdiff <= '0;
            s1_fd_th <= '0;
            s1_alpha <= '0;
            s1_bg_th <= '0;
            s1_mode  <= MODE_SELECTIVE;
        end else if (en) begin
            s1_valid <= s_valid;
            s1_last  <= s_last;
            s1_cur   <= s_current;
            s1_bg    <= s_background;
            s1_diff  <= diff;
            s1_mdiff <= mdiff;
            s1_fd_th <= fd_th;
            s1_alpha <= alpha_clamped;
            s1_bg_th <= bg_th;
            s1_mode  <= mode_t'(mode);
        end
    end

    // ---------------- stage 2: weighted sum and thresholds ----------------
    logic [SW-1:0] chroma_sum, weighted;

    always_comb begin
        chroma_sum = '0;
        for (int k = 1; k < CHANNELS; k++) begin
            chroma_sum = chroma_sum + SW'(s1_diff[(CHANNELS-k)*CH_WIDTH-1 -: CH_WIDTH]);
        end
        weighted = (SW'(s1_diff[PW-1 -: CH_WIDTH]) << LUMA_SHIFT) + (chroma_sum << CHROMA_SHIFT);
    end

    logic          s2_valid, s2_last, s2_fg, s2_mov;
    logic [PW-1:0] s2_cur, s2_bg;
    logic [AW-1:0] s2_alpha;
    mode_t         s2_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_fg    <= 1'b0;
            s2_mov   <= 1'b0;
            s2_cur   <= '0;
            s2_bg    <= '0;
            s2_alpha <= '0;
            s2_mode  <= MODE_SELECTIVE;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_fg    <= CW'(weighted) > CW'(s1_bg_th);
            s2_mov   <= s1_mdiff > s1_fd_th;
            s2_cur   <= s1_cur;
            s2_bg    <= s1_bg;
            s2_alpha <= s1_alpha;
            s2_mode  <= s1_mode;
        end
    end

    // ---------------- stage 3: rounded alpha blend ----------------
    logic [PW-1:0] blend;

    for (gi = 0; gi < CHANNELS; gi++) begin : g_blend
        localparam int HI = (CHANNELS - gi) * CH_WIDTH - 1;
        logic [BW-1:0] acc;
        assign acc = BW'(s2_alpha) * BW'(s2_cur[HI -: CH_WIDTH])
                   + BW'(A_ONE - s2_alpha) * BW'(s2_bg[HI -: CH_WIDTH])
                   + HALF;
        // alpha is clamped, so the shifted sum always fits in one channel
        assign blend[HI -: CH_WIDTH] = CH_WIDTH'(acc >> ALPHA_FRAC);
    end

    logic          s3_valid, s3_last, s3_fg, s3_mov;
    logic [PW-1:0] s3_cur, s3_bg, s3_upd;
    mode_t         s3_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_fg    <= 1'b0;
            s3_mov   <= 1'b0;
            s3_cur   <= '0;
            s3_bg    <= '0;
            s3_upd   <= '0;
            s3_mode  <= MODE_SELECTIVE;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_fg    <= s2_fg;
            s3_mov   <= s2_mov;
            s3_cur   <= s2_cur;
            s3_bg    <= s2_bg;
            s3_upd   <= blend;
            s3_mode  <= s2_mode;
        end
    end

    // ---------------- stage 4: background select and outputs ----------------
    logic [PW-1:0] sel;

    always_comb begin
        sel = s3_cur;
        case (s3_mode)
            MODE_SELECTIVE: sel = (!s3_fg && !s3_mov) ? s3_upd : s3_bg;
            MODE_ALWAYS:    sel = s3_upd;
            MODE_FREEZE:    sel = s3_bg;
            MODE_CURRENT:   sel = s3_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_background <= '0;
            m_foreground <= '0;
            m_movement   <= '0;
        end else if (en) begin
            m_valid      <= s3_valid;
            m_last       <= s3_last;
            m_background <= sel;
            m_foreground <= {PW{s3_fg}};
            m_movement   <= {PW{s3_mov}};
        end
    end

    // ---------------- per-frame foreground counter ----------------
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 fire;

    assign fire     = m_valid && m_ready;
    assign cnt_next = (m_foreground[0] && (cnt_reg != {CNT_WIDTH{1'b1}})) ? cnt_reg + CNT_WIDTH'(1) : cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            fg_count       <= '0;
            fg_count_valid <= 1'b0;
        end else begin
            fg_count_valid <= 1'b0;
            if (fire) begin
                if (m_last) begin
                    fg_count       <= cnt_next;
                    fg_count_valid <= 1'b1;
                    cnt_reg        <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    end

endmodule
